instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache. It serves the fetch requests that the instruction unit issues (PC plus request-valid) and returns the instruction word, the address it belongs to and a valid flag. On a miss it refills a whole line from the memory controller, one word per request/response handshake.

---
 rtl/instruction_cache.sv | 145 ++++++++++++++
 tb/tb_instruction_cache.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational tag lookup in IDLE,
// whole-line refill from the memory controller one word per handshake on a miss.
module instruction_cache #(
   parameter int INDEX_WIDTH     = 4,
   parameter int LINE_WORD_WIDTH = 2
) (
   input  logic        clockIn,
   input  logic        resetIn,
   input  logic        requestValid,
   input  logic [31:0] requestAddr,
   input  logic        clearIn,
   output logic        instrOutValid,
   output logic [31:0] instrOut,
   output logic [31:0] instrAddrOut,
   output logic        memRequest,
   output logic [31:0] memAddr,
   input  logic        memDataValid,
   input  logic [31:0] memData
);

   localparam int LINES  = 1 << INDEX_WIDTH;
   localparam int WORDS  = 1 << LINE_WORD_WIDTH;
   localparam int IDX_LO = LINE_WORD_WIDTH + 2;
   localparam int TAG_LO = IDX_LO + INDEX_WIDTH;
   localparam int TAG_W  = 32 - TAG_LO;

   typedef enum logic {
      S_IDLE,
      S_REFILL
   } state_t;

   state_t                     state_q, state_d;
   logic [LINES-1:0]           valid_q, valid_d;
   logic [31:0]                base_q, base_d;
   logic [LINE_WORD_WIDTH-1:0] count_q, count_d;
   logic                       poison_q, poison_d;
   logic                       out_valid_q, out_valid_d;
   logic [31:0]                out_instr_q, out_instr_d;
   logic [31:0]                out_addr_q, out_addr_d;

   logic [TAG_W-1:0]           tag_mem  [LINES];
   logic [31:0]                data_mem [LINES*WORDS];

   logic [INDEX_WIDTH-1:0]     req_index;
   logic [LINE_WORD_WIDTH-1:0] req_offset;
   logic [TAG_W-1:0]           req_tag;
   logic [INDEX_WIDTH-1:0]     fill_index;
   logic [31:0]                hit_word;
   logic                       lookup_hit;
   logic                       word_accept;
   logic                       last_word;
   logic                       unused_addr_bits;

   assign req_index        = requestAddr[TAG_LO-1:IDX_LO];
   assign req_offset       = requestAddr[IDX_LO-1:2];
   assign req_tag          = requestAddr[31:TAG_LO];
   assign fill_index       = base_q[TAG_LO-1:IDX_LO];
   assign hit_word         = data_mem[{req_index, req_offset}];
   assign lookup_hit       = valid_q[req_index] && (tag_mem[req_index] == req_tag);
   assign word_accept      = (state_q == S_REFILL) && memDataValid;
   assign last_word        = &count_q;
   assign unused_addr_bits = ^requestAddr[1:0];

   // The base is line-aligned, so OR-ing in the word offset never carries.
   assign memRequest    = (state_q == S_REFILL);
   assign memAddr       = memRequest ?
                          (base_q | {{(32-IDX_LO){1'b0}}, count_q, 2'b00}) : 32'd0;
   assign instrOutValid = out_valid_q;
   assign instrOut      = out_instr_q;
   assign instrAddrOut  = out_addr_q;

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      base_d      = base_q;
      count_d     = count_q;
      poison_d    = poison_q;
      out_valid_d = 1'b0;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;

      case (state_q)
         S_IDLE: begin
            if (requestValid) begin
               if (lookup_hit) begin
                  out_valid_d = 1'b1;
                  out_instr_d = hit_word;
                  out_addr_d  = requestAddr;
               end else begin
                  // Line is overwritten word by word, so it must not hit meanwhile.
                  valid_d[req_index] = 1'b0;
                  base_d   = {requestAddr[31:IDX_LO], {IDX_LO{1'b0}}};
                  count_d  = '0;
                  poison_d = 1'b0;
                  state_d  = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            if (word_accept) begin
               count_d = count_q + 1'b1;
               if (last_word) begin
                  state_d = S_IDLE;
                  if (!poison_q) valid_d[fill_index] = 1'b1;
               end
            end
            if (clearIn) poison_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A flush wins over a line completing on the same edge.
      if (clearIn) valid_d = '0;
   end

   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         base_q      <= '0;
         count_q     <= '0;
         poison_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         base_q      <= base_d;
         count_q     <= count_d;
         poison_q    <= poison_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
      end
   end

   always_ff @(posedge clockIn) begin
      if (word_accept) begin
         data_mem[{fill_index, count_q}] <= memData;
         if (last_word) tag_mem[fill_index] <= base_q[31:TAG_LO];
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised bench for instruction_cache against a transaction-level cache model
// and a memory responder with programmable latency.
module tb_instruction_cache;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        clear;
   logic        out_valid;
   logic [31:0] instr;
   logic [31:0] iaddr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_dv;
   logic [31:0] mem_data;

   always #5 clk = ~clk;

   instruction_cache dut (
      .clockIn      (clk),
      .resetIn      (rst_n),
      .requestValid (req_valid),
      .requestAddr  (req_addr),
      .clearIn      (clear),
      .instrOutValid(out_valid),
      .instrOut     (instr),
      .instrAddrOut (iaddr),
      .memRequest   (mem_req),
      .memAddr      (mem_addr),
      .memDataValid (mem_dv),
      .memData      (mem_data)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat_k    = 1;
   logic [31:0] salt     = 32'hA5A5A5A5;
   int          mem_wait = 0;
   logic        mem_prev_req = 1'b0;
   logic [31:0] mem_prev_addr = '0;

   // Model: per line valid, tag and the words it should hold.
   bit          m_valid [16];
   logic [23:0] m_tag   [16];
   logic [31:0] m_data  [16][4];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ salt;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
   endtask

   // Advance one clock; the responder answers an address in the lat_k-th cycle
   // it has been presented, so each word costs lat_k edges.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (mem_req) begin
         if (mem_prev_req && mem_addr == mem_prev_addr) mem_wait++;
         else mem_wait = 1;
      end else begin
         mem_wait = 0;
      end
      mem_prev_req  = mem_req;
      mem_prev_addr = mem_addr;
      mem_dv   = mem_req && (mem_wait >= lat_k);
      mem_data = mem_dv ? mem_word(mem_addr) : $urandom;
   endtask

   task automatic idle(input int n, input bit stray);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (stray && i == 0) begin
            mem_dv   = 1'b1;
            mem_data = $urandom;
         end
         cycle();
         check("idle_valid", 32'(out_valid), 32'd0);
         check("idle_memreq", 32'(mem_req), 32'd0);
      end
   endtask

   // clr_word >= 0: pulse clearIn on the first cycle awaiting that word
   // (or in the request cycle of a hit).
   task automatic fetch(input logic [31:0] addr, input int clr_word);
      int          idx;
      int          off;
      int          words;
      int          edges;
      bit          hit;
      bit          poisoned;
      bit          acc;
      logic [31:0] base;
      logic [31:0] line_buf [4];
      idx      = int'(addr[7:4]);
      off      = int'(addr[3:2]);
      base     = {addr[31:4], 4'h0};
      hit      = m_valid[idx] && (m_tag[idx] == addr[31:8]);
      poisoned = 1'b0;
      words    = 0;
      edges    = 0;
      req_valid = 1'b1;
      req_addr  = addr;
      if (hit) begin
         if (clr_word >= 0) begin
            clear = 1'b1;
            model_clear();
         end
         cycle();
         clear = 1'b0;
         req_valid = 1'b0;
         check("hit_valid", 32'(out_valid), 32'd1);
         check("hit_addr", iaddr, addr);
         check("hit_data", instr, m_data[idx][off]);
         check("hit_no_memreq", 32'(mem_req), 32'd0);
         $display("fetch %h hit  data=%h clr=%0d", addr, instr, clr_word);
         return;
      end
      m_valid[idx] = 1'b0;
      cycle();
      while (words < 4 && edges < 200) begin
         check("refill_req", 32'(mem_req), 32'd1);
         check("refill_addr", mem_addr, base + 32'(4 * words));
         check("refill_no_valid", 32'(out_valid), 32'd0);
         if (words == clr_word && !poisoned) begin
            clear    = 1'b1;
            poisoned = 1'b1;
            model_clear();
         end
         acc = mem_dv;
         cycle();
         clear = 1'b0;
         edges++;
         if (acc) begin
            line_buf[words] = mem_word(base + 32'(4 * words));
            words++;
         end
      end
      if (words < 4) begin
         check("refill_timeout", 32'(words), 32'd4);
         req_valid = 1'b0;
         return;
      end
      check("refill_done_memreq", 32'(mem_req), 32'd0);
      check("refill_done_valid", 32'(out_valid), 32'd0);
      m_tag[idx] = addr[31:8];
      for (int w = 0; w < 4; w++) m_data[idx][w] = line_buf[w];
      m_valid[idx] = !poisoned;
      if (poisoned) begin
         req_valid = 1'b0;
         $display("fetch %h miss poisoned, line stays invalid", addr);
         return;
      end
      cycle();
      edges++;
      req_valid = 1'b0;
      check("fill_hit_valid", 32'(out_valid), 32'd1);
      check("fill_hit_addr", iaddr, addr);
      check("fill_hit_data", instr, m_data[idx][off]);
      // Cycles from the missing request edge up to and including the valid cycle.
      check("miss_latency", 32'(edges + 1), 32'(4 * lat_k + 2));
      $display("fetch %h miss data=%h latency=%0d k=%0d", addr, instr, edges + 1, lat_k);
   endtask

   initial begin
      int words;
      bit acc;
      logic [31:0] a;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; clear = 1'b0;
      mem_dv = 1'b0; mem_data = '0;
      repeat (3) cycle();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_iaddr", iaddr, 32'd0);
      check("rst_memreq", 32'(mem_req), 32'd0);
      check("rst_memaddr", mem_addr, 32'd0);
      rst_n = 1'b1;
      idle(1, 1'b0);

      // Cold miss, then streaming hits, then conflict eviction.
      lat_k = 1;
      fetch(32'h0000_0004, -1);
      fetch(32'h0000_0000, -1);
      fetch(32'h0000_0004, -1);
      fetch(32'h0000_0008, -1);
      fetch(32'h0000_000C, -1);
      fetch(32'h0000_0100, -1);
      fetch(32'h0000_0000, -1);

      // Flush while awaiting word 2, flush on the last response edge.
      fetch(32'h0000_0040, 2);
      fetch(32'h0000_0040, -1);
      fetch(32'h0000_0000, -1);
      fetch(32'h0000_0054, 3);
      fetch(32'h0000_0054, -1);
      fetch(32'hFFFF_FFF8, -1);

      // Slow memory, stray strobe, hit with flush in the same cycle.
      lat_k = 3;
      salt  = 32'h1234_5678;
      idle(2, 1'b1);
      fetch(32'h0000_0200, -1);
      fetch(32'h0000_0204, 0);
      fetch(32'h0000_0204, -1);

      // Asynchronous reset after word 1 of a refill.
      lat_k = 2;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0280;
      cycle();
      words = 0;
      for (int i = 0; i < 50 && words < 1; i++) begin
         acc = mem_dv;
         cycle();
         if (acc) words++;
      end
      #2 rst_n = 1'b0;
      #1;
      check("amid_memreq", 32'(mem_req), 32'd0);
      check("amid_valid", 32'(out_valid), 32'd0);
      check("amid_memaddr", mem_addr, 32'd0);
      model_clear();
      req_valid = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      $display("reset asserted mid-refill of 00000280 after word 1");
      idle(1, 1'b1);
      fetch(32'h0000_0280, -1);

      // Random traffic over a few tags so hits, misses and evictions mix.
      for (int t = 0; t < 150; t++) begin
         lat_k = int'($urandom_range(1, 3));
         if ($urandom_range(0, 19) == 0) salt = $urandom;
         a = {22'd0, 2'($urandom_range(0, 2)), 4'($urandom), 2'($urandom), 2'b00};
         if ($urandom_range(0, 11) == 0) fetch(a, int'($urandom_range(0, 3)));
         else fetch(a, -1);
         if ($urandom_range(0, 7) == 0) idle(1, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
